// File: rtl/interp_phase_ctrl.sv
// Fractional-phase controller for a polyphase interpolator. Accumulates
// timing-error corrections into mu and, on each accepted sample, selects a
// filter phase, absorbing phase wraps as sample skips or sample stuffs.
module interp_phase_ctrl #(
  parameter int NB_ERR   = 10,
  parameter int NB_MU    = 8,
  parameter int KP_SHIFT = 2,
  parameter int MIN_GAP  = 4,
  parameter int PIPE_LAT = 6
) (
  input  logic                     clk,
  input  logic                     i_srst,
  input  logic                     i_valid,
  input  logic signed [NB_ERR-1:0] i_err,
  input  logic                     i_err_valid,
  input  logic                     i_loop_en,
  output logic                     o_en,
  output logic [3:0]               o_coeff_sel,
  output logic                     o_os_valid,
  output logic [NB_MU-1:0]         o_mu,
  output logic                     o_skip,
  output logic                     o_stuff,
  output logic                     o_overrun
);

  localparam int CW = ((NB_ERR > NB_MU + 1) ? NB_ERR : NB_MU + 1) + 1;
  localparam int SW = NB_MU + 2;
  localparam int GW = $clog2(2 * MIN_GAP + 1);

  localparam logic signed [CW-1:0] CORR_MAX = CW'((2 ** NB_MU) - 1);
  localparam logic signed [CW-1:0] CORR_MIN = -CORR_MAX;
  localparam logic [NB_MU-1:0]     MU_RST   = {1'b1, {(NB_MU-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, STUFF_ISSUE, STUFF_WAIT} state_t;

  state_t                   state, state_nxt;
  logic [GW-1:0]            gap;
  logic signed [NB_ERR-1:0] err_shift;
  logic signed [CW-1:0]     err_ext;
  logic signed [NB_MU:0]    corr_sat, corr_pend;
  logic signed [SW-1:0]     sum;
  logic                     sum_neg, sum_ovf;
  logic                     accept, drop, issue;
  logic [PIPE_LAT-1:0]      os_pipe;

  // Loop-gain scaling, then clamp to the symmetric range mu can absorb.
  assign err_shift = i_err >>> KP_SHIFT;
  assign err_ext   = CW'(err_shift);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    corr_sat = err_ext[NB_MU:0];
    if (err_ext > CORR_MAX)
      corr_sat = CORR_MAX[NB_MU:0];
    else if (err_ext < CORR_MIN)
      corr_sat = CORR_MIN[NB_MU:0];
  end

  // Wrap detection: negative sum means stuff, sum >= 2^NB_MU means skip;
  // in every case the new mu is simply the low NB_MU bits of the sum.
  assign sum     = SW'($signed({1'b0, o_mu})) + SW'(corr_pend);
  assign sum_neg = sum[SW-1];
  assign sum_ovf = !sum[SW-1] && sum[NB_MU];

  always_comb begin
    accept = i_valid && !i_srst && (state == IDLE);
    drop   = i_valid && !i_srst && (state != IDLE);
    issue  = (state == STUFF_ISSUE) && (gap == GW'(MIN_GAP));
    o_en   = accept;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept) state_nxt = sum_neg ? STUFF_ISSUE : WAIT;
      WAIT:        if (gap == GW'(MIN_GAP - 1)) state_nxt = IDLE;
      STUFF_ISSUE: if (issue) state_nxt = STUFF_WAIT;
      STUFF_WAIT:  if (gap == GW'(2 * MIN_GAP - 1)) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_srst) begin
      state <= IDLE;
      gap   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE)
        gap <= '0;
      else if (accept)
        gap <= GW'(1);
      else
        gap <= gap + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the reset clears the strobe pipeline too, cancelling any output still in flight.
    if (i_srst) begin
      o_mu        <= MU_RST;
      o_coeff_sel <= 4'd8;
      corr_pend   <= '0;
      os_pipe     <= '0;
      o_skip      <= 1'b0;
      o_stuff     <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_skip    <= accept && sum_ovf;
      o_stuff   <= accept && sum_neg;
      o_overrun <= drop;
      os_pipe   <= {os_pipe[PIPE_LAT-2:0], (accept && !sum_ovf) || issue};

      if (accept) begin
        o_mu        <= sum[NB_MU-1:0];
        o_coeff_sel <= sum_neg ? 4'd0 : sum[NB_MU-1 -: 4];
      end else if (issue) begin
        o_coeff_sel <= o_mu[NB_MU-1 -: 4];
      end

      // A fresh error outranks the clear, so it waits for the next sample.
      if (i_err_valid && i_loop_en)
        corr_pend <= corr_sat;
      else if (accept)
        corr_pend <= '0;
    end
  end

  assign o_os_valid = os_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_interp_phase_ctrl.sv
// Bench for interp_phase_ctrl: two instances (KP_SHIFT 2 and 0) driven in
// parallel, checked every cycle against a cycle-schedule model plus literals.
module tb_interp_phase_ctrl;

  localparam int MG = 4;
  localparam int PL = 6;
  localparam int KS [2] = '{2, 0};

  logic clk = 1'b0;
  logic srst = 1'b0, valid = 1'b0, err_valid = 1'b0, loop_en = 1'b0;
  logic signed [9:0] err = '0;

  logic       en_o    [2];
  logic [3:0] sel_o   [2];
  logic       os_o    [2];
  logic [7:0] mu_o    [2];
  logic       skip_o  [2];
  logic       stuff_o [2];
  logic       ovr_o   [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Model: absolute cycle numbers for busy end, stuff re-issue and strobes.
  int          m_mu [2]       = '{128, 128};
  int          m_sel [2]      = '{8, 8};
  int          m_corr [2]     = '{0, 0};
  int          m_busy_end [2] = '{0, 0};
  int          m_issue [2]    = '{-1, -1};
  bit          ex_skip [2]    = '{0, 0};
  bit          ex_stuff [2]   = '{0, 0};
  bit          ex_ovr [2]     = '{0, 0};
  logic [63:0] os_ring [2]    = '{64'd0, 64'd0};

  always #5 clk = ~clk;

  interp_phase_ctrl #(.KP_SHIFT(2)) u_dut_k2 (
    .clk(clk), .i_srst(srst), .i_valid(valid), .i_err(err),
    .i_err_valid(err_valid), .i_loop_en(loop_en),
    .o_en(en_o[0]), .o_coeff_sel(sel_o[0]), .o_os_valid(os_o[0]),
    .o_mu(mu_o[0]), .o_skip(skip_o[0]), .o_stuff(stuff_o[0]), .o_overrun(ovr_o[0])
  );

  interp_phase_ctrl #(.KP_SHIFT(0)) u_dut_k0 (
    .clk(clk), .i_srst(srst), .i_valid(valid), .i_err(err),
    .i_err_valid(err_valid), .i_loop_en(loop_en),
    .o_en(en_o[1]), .o_coeff_sel(sel_o[1]), .o_os_valid(os_o[1]),
    .o_mu(mu_o[1]), .o_skip(skip_o[1]), .o_stuff(stuff_o[1]), .o_overrun(ovr_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic mark_os(input int i, input int due);
    os_ring[i][due % 64] = 1'b1;
  endtask

  task automatic model_step(input int i);
    int c, sum, e;
    c = cyc;
    ex_skip[i]  = 1'b0;
    ex_stuff[i] = 1'b0;
    ex_ovr[i]   = 1'b0;
    if (srst) begin
      m_mu[i] = 128; m_sel[i] = 8; m_corr[i] = 0;
      m_busy_end[i] = c + 1; m_issue[i] = -1; os_ring[i] = '0;
      return;
    end
    if (c == m_issue[i]) begin
      m_sel[i] = m_mu[i] / 16;
      mark_os(i, c + PL);
    end
    if (valid) begin
      if (c >= m_busy_end[i]) begin
        sum = m_mu[i] + m_corr[i];
        m_corr[i] = 0;
        if (sum < 0) begin
          m_mu[i] = sum + 256; m_sel[i] = 0; ex_stuff[i] = 1'b1;
          mark_os(i, c + PL);
          m_busy_end[i] = c + 2 * MG; m_issue[i] = c + MG;
        end else if (sum >= 256) begin
          m_mu[i] = sum - 256; m_sel[i] = m_mu[i] / 16; ex_skip[i] = 1'b1;
          m_busy_end[i] = c + MG;
        end else begin
          m_mu[i] = sum; m_sel[i] = sum / 16;
          mark_os(i, c + PL);
          m_busy_end[i] = c + MG;
        end
      end else begin
        ex_ovr[i] = 1'b1;
      end
    end
    if (err_valid && loop_en) begin
      e = int'(err) >>> KS[i];
      if (e > 255) e = 255;
      if (e < -255) e = -255;
      m_corr[i] = e;
    end
  endtask

  // Compare process: every cycle, both instances against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit e_os;
      e_os = os_ring[i][cyc % 64];
      os_ring[i][cyc % 64] = 1'b0;
      if (armed) begin
        check($sformatf("u%0d o_en", i), en_o[i], valid && !srst && (cyc >= m_busy_end[i]));
        check($sformatf("u%0d o_coeff_sel", i), sel_o[i], m_sel[i]);
        check($sformatf("u%0d o_os_valid", i), os_o[i], e_os);
        check($sformatf("u%0d o_mu", i), mu_o[i], m_mu[i]);
        check($sformatf("u%0d o_skip", i), skip_o[i], ex_skip[i]);
        check($sformatf("u%0d o_stuff", i), stuff_o[i], ex_stuff[i]);
        check($sformatf("u%0d o_overrun", i), ovr_o[i], ex_ovr[i]);
      end
      model_step(i);
    end
    if (srst) armed = 1'b1;
    cyc++;
  end

  task automatic tick(input logic v, input logic ev, input logic signed [9:0] e,
                      input logic le, input logic rst);
    @(posedge clk);
    #1;
    valid = v; err_valid = ev; err = e; loop_en = le; srst = rst;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then a lone sample at cycle 10 with no error.
    tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b1);
    idle(8);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    check("lit first o_en", en_o[0], 1'b1);
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      if (k == 1) begin
        check("lit first coeff_sel", sel_o[0], 4'd8);
        check("lit first mu", mu_o[0], 8'd128);
      end
      check("lit first os_valid", os_o[0], k == 6);
    end

    // +64 error at gain 2 -> corr 16, mu 128 -> 144.
    tick(1'b0, 1'b1, 10'sd64, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    idle(1);
    check("lit corr16 mu", mu_o[0], 8'd144);
    check("lit corr16 coeff_sel", sel_o[0], 4'd9);
    idle(10);

    // Walk mu to 240 (corr 96), then skip with corr 32.
    tick(1'b0, 1'b1, 10'sd384, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    idle(1);
    check("lit mu240", mu_o[0], 8'd240);
    idle(10);
    tick(1'b0, 1'b1, 10'sd128, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      if (k == 1) begin
        check("lit skip mu", mu_o[0], 8'd16);
        check("lit skip coeff_sel", sel_o[0], 4'd1);
        check("lit skip pulse", skip_o[0], 1'b1);
      end
      check("lit skip os_valid", os_o[0], 1'b0);
    end
    idle(10);

    // Walk mu to 8 (corr -8), then stuff with corr -16.
    tick(1'b0, 1'b1, -10'sd32, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    idle(10);
    check("lit mu8", mu_o[0], 8'd8);
    tick(1'b0, 1'b1, -10'sd64, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      idle(1);
      if (k == 1) begin
        check("lit stuff mu", mu_o[0], 8'd248);
        check("lit stuff pulse", stuff_o[0], 1'b1);
      end
      check("lit stuff coeff_sel", sel_o[0], (k <= 4) ? 4'd0 : 4'd15);
      check("lit stuff os_valid", os_o[0], (k == 6) || (k == 10));
    end
    idle(10);

    // Overrun: second i_valid two cycles after an accepted one.
    tick(1'b0, 1'b1, 10'sd8, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    check("lit ovr first o_en", en_o[0], 1'b1);
    idle(1);
    check("lit ovr mu after accept", mu_o[0], 8'd250);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    check("lit ovr second o_en", en_o[0], 1'b0);
    idle(1);
    check("lit ovr pulse", ovr_o[0], 1'b1);
    check("lit ovr mu held", mu_o[0], 8'd250);
    idle(10);

    // Saturation at gain 0, then reset mid-flight cancels all strobes.
    tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, -10'sd512, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b0);
    idle(1);
    check("lit sat k2 mu", mu_o[0], 8'd0);
    check("lit sat k0 mu", mu_o[1], 8'd129);
    check("lit sat k0 stuff", stuff_o[1], 1'b1);
    idle(1);
    tick(1'b0, 1'b0, 10'sd0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 10'sd0, 1'b0, 1'b1);
    check("lit valid in reset o_en", en_o[0], 1'b0);
    check("lit valid in reset o_en k0", en_o[1], 1'b0);
    for (int k = 5; k <= 11; k++) begin
      idle(1);
      if (k == 5) check("lit reset mu", mu_o[1], 8'd128);
      check("lit reset os_valid k2", os_o[0], 1'b0);
      check("lit reset os_valid k0", os_o[1], 1'b0);
    end

    // Randomized traffic against the model.
    repeat (3000) begin
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, 10'($urandom),
           $urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interp_phase_ctrl.md
INTERP_PHASE_CTRL -- requirements
Module: interp_phase_ctrl

Interface
REQ-001 The block SHALL have parameter NB_ERR, default 10, meaning the width of the signed timing-error input.
REQ-002 The block SHALL have parameter NB_MU, default 8, meaning the width of the unsigned fractional-phase accumulator; phase index = mu[NB_MU-1 -: 4].
REQ-003 The block SHALL have parameter KP_SHIFT, default 2, meaning the arithmetic right shift applied to the error (loop gain).
REQ-004 The block SHALL have parameter MIN_GAP, default 4, meaning the minimum cycles between accepted samples.
REQ-005 The block SHALL have parameter PIPE_LAT, default 6, meaning the cycles from o_en to the matching filter output.
REQ-006 The block SHALL have one clock and a synchronous active-high reset: clk, input, 1, rising-edge clock; i_srst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have i_valid, input, 1, input-sample strobe, one cycle per sample.
REQ-008 The block SHALL have i_err, input, NB_ERR signed, timing error from the detector.
REQ-009 The block SHALL have i_err_valid, input, 1, qualifies i_err.
REQ-010 The block SHALL have i_loop_en, input, 1, loop enable; when 0 the error is ignored.
REQ-011 The block SHALL have o_en, output, 1, shift enable driving the filter i_en.
REQ-012 The block SHALL have o_coeff_sel, output, 4, phase select driving the filter coeff_sel.
REQ-013 The block SHALL have o_os_valid, output, 1, high in the cycle the filter output is valid.
REQ-014 The block SHALL have o_mu, output, NB_MU, current accumulator value.
REQ-015 The block SHALL have o_skip, output, 1, o_stuff, output, 1, and o_overrun, output, 1, each a one-cycle event pulse.

Function
REQ-016 o_en SHALL equal i_valid AND (state==IDLE), combinationally; every other output SHALL be registered.
REQ-017 The states SHALL be IDLE, WAIT, STUFF_ISSUE and STUFF_WAIT, with a gap counter.
REQ-018 When i_err_valid && i_loop_en, corr_pend SHALL latch (i_err >>> KP_SHIFT), saturated to ±(2^NB_MU - 1); a later error before use SHALL overwrite it.
REQ-019 On an accepted i_valid (cycle t0), sum = mu + corr_pend SHALL be computed signed at NB_MU+2 bits, and corr_pend SHALL clear to 0.
REQ-019a If an error is latched in cycle t0 itself, that error SHALL wait for the next accepted sample.
REQ-020 Normal case (0 <= sum < 2^NB_MU): mu <= sum, o_coeff_sel <= sum[NB_MU-1 -: 4] visible at t0+1, and o_os_valid SHALL be high at t0+PIPE_LAT.
REQ-021 Skip case (sum >= 2^NB_MU): mu <= sum - 2^NB_MU, o_coeff_sel updated, o_skip pulses at t0+1, and no o_os_valid for this sample.
REQ-022 Stuff case (sum < 0): mu <= sum + 2^NB_MU, o_stuff pulses at t0+1, o_coeff_sel <= 0 at t0+1, and o_os_valid is high at t0+PIPE_LAT.
REQ-022a In the stuff case, the state SHALL go to STUFF_ISSUE; at t0+MIN_GAP o_coeff_sel <= new phase, with no o_en.
REQ-022b In the stuff case, a second o_os_valid SHALL occur at t0+MIN_GAP+PIPE_LAT.
REQ-023 After acceptance the block SHALL be busy: WAIT until t0+MIN_GAP (normal/skip) or STUFF_WAIT until t0+2*MIN_GAP (stuff), then return to IDLE.
REQ-024 An i_valid while busy SHALL be dropped: o_en low, o_overrun pulses next cycle, and mu is unchanged.
REQ-025 Pending o_os_valid strobes SHALL be tracked by a PIPE_LAT-deep shift register, independent of new acceptances.
REQ-026 o_mu SHALL reflect mu from t0+1.

Reset
REQ-027 On i_srst, mu SHALL be 2^(NB_MU-1) (128), o_coeff_sel 8, corr_pend 0, and state IDLE.
REQ-028 On i_srst, the valid pipeline SHALL clear and all pulse outputs SHALL be 0.
REQ-029 Reset mid-operation SHALL cancel all pending o_os_valid and any stuff second output.
REQ-030 An i_valid coincident with i_srst SHALL be ignored (o_en=0).

Verification
REQ-031 Reset, then i_valid at cycle 10 with no error -> o_en high at 10, o_coeff_sel=8 at 11, o_os_valid high at 16 only.
REQ-032 i_err=+64, KP_SHIFT=2, then i_valid -> corr=16, o_mu 128->144, o_coeff_sel=9.
REQ-033 mu=240, corr=+32, i_valid at t0 -> o_mu=16, o_coeff_sel=1, o_skip at t0+1, no o_os_valid.
REQ-034 mu=8, corr=-16, i_valid at t0 -> o_mu=248, o_stuff at t0+1.
REQ-034a In the same stuff scenario, o_coeff_sel=0 then 15 at t0+5, and o_os_valid at t0+6 and t0+10.
REQ-035 i_valid at t0 and t0+2 -> second o_en low, o_overrun at t0+3, o_mu changed once.
REQ-036 i_err=-512, KP_SHIFT=0 -> corr saturates to -255; also assert i_srst at t0+3 -> no o_os_valid at t0+6.
